// File: rtl/ahb_apb_bridge_pkg.sv
// Shared definitions for the AHB-to-APB bridge request path.
// A queued request entry is laid out MSB-first as {WRITE, ADDR, DATA}.
package ahb_apb_bridge_pkg;

    // The write-data field always starts at bit 0 of an entry.
    localparam int DATA_LSB = 0;

    // Total entry width: direction bit + address + write data.
    function automatic int entry_width(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

    // The address field sits directly above the write data.
    function automatic int addr_lsb(input int data_w);
        return data_w;
    endfunction

    // The direction bit is the entry MSB.
    function automatic int write_bit(input int addr_w, input int data_w);
        return addr_w + data_w;
    endfunction

endpackage

// File: rtl/ahb_apb_fifo_mem.sv
// Request storage: DEPTH x WIDTH register array.
// It has a synchronous write port and an asynchronous read port, so the
// head entry is visible in the same cycle its pointer changes.
// The array resets to 0, which keeps the head outputs defined out of reset.
module ahb_apb_fifo_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 65,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_we,
    input  logic [PTR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [PTR_W-1:0] i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write the addressed entry on the rising edge; clear the array on reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ahb_apb_req_fifo.sv
// Request FIFO between the AHB slave interface and the APB master FSM.
// It queues complete requests {direction, address, write data} and shows the
// oldest one first-word-fall-through. It also reports occupancy, full and
// almost-full, and keeps sticky overflow/underflow flags.
// Handshake: an entry enters on valid && !full and leaves on Pready && transfer.
// full and transfer come only from the registered count, so the producer never
// races a same-cycle change. A push refused while full is lost, not retried.
module ahb_apb_req_fifo
    import ahb_apb_bridge_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic                       Hclk,
    input  logic                       Hresetn,
    input  logic                       valid,
    input  logic                       Hwrite_temp,
    input  logic [ADDR_W-1:0]          Haddr_temp,
    input  logic [DATA_W-1:0]          Hwdata_temp,
    input  logic                       flush,
    input  logic                       Pready,
    output logic                       transfer,
    output logic                       write_out,
    output logic [ADDR_W-1:0]          addr_out,
    output logic [DATA_W-1:0]          data_out,
    output logic                       full,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = entry_width(ADDR_W, DATA_W);
    localparam int WR_BIT  = write_bit(ADDR_W, DATA_W);
    localparam int A_LSB   = addr_lsb(DATA_W);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);

    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_overflow;
    logic               r_underflow;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic [ENTRY_W-1:0] w_entry;
    logic [ENTRY_W-1:0] w_head;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    // flush overrides both sides. Pointers wrap naturally because DEPTH is a
    // power of two.
    assign w_push  = valid  && !w_full  && !flush;
    assign w_pop   = Pready && !w_empty && !flush;
    assign w_entry = {Hwrite_temp, Haddr_temp, Hwdata_temp};

    ahb_apb_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .PTR_W (PTR_W)
    ) u_mem (
        .i_clk   (Hclk),
        .i_rst_n (Hresetn),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_entry),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );

    // Pointer and occupancy update; flush returns all three to empty.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Sticky error flags record any attempt against a full or empty FIFO.
    // Only reset clears them.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (valid && w_full) begin
                r_overflow <= 1'b1;
            end
            if (Pready && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign transfer    = !w_empty;
    assign full        = w_full;
    assign almost_full = (r_count >= AF_CNT);
    assign count       = r_count;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

    assign write_out = w_head[WR_BIT];
    assign addr_out  = w_head[A_LSB +: ADDR_W];
    assign data_out  = w_head[DATA_LSB +: DATA_W];

endmodule
